if_pc_redirect: RTL and testbench
=================================

// Module: if_pc_redirect
// PURPOSE
// - Fetch-stage PC sequencer; consumes the Jump/Branch/jmp_r control bits once resolved in EX.
// - Holds the PC; predicts not-taken (PC+2); redirects on jump or taken branch; squashes wrong-path IF/ID slots.
// - Freezes fetch on HALT retire.
// PARAMETERS
// PC_W          16      PC and target width (bits)
// RESET_PC      16'h0   PC value loaded on reset
// INSTR_BYTES   2       sequential PC increment
// FLUSH_CYCLES  2       cycles flush held after a redirect (wrong-path slots IF+ID); legal 1..7
// PORTS
// clk          in   1     clock, rising edge
// rst_n        in   1     synchronous active-low reset
// stall        in   1     hazard stall; hold PC
// res_valid    in   1     EX holds a valid, non-squashed control-flow instruction this cycle
// res_jump     in   1     resolved Jump bit (J/JR/JAL/JALR)
// res_jmp_r    in   1     resolved jmp_r bit (JR/JALR: register-relative target)
// res_branch   in   1     resolved Branch bit (BEQZ/BNEZ/BLTZ/BGEZ)
// res_taken    in   1     branch condition result from EX
// res_pc_plus2 in   PC_W  PC+2 of the resolving instruction
// res_imm      in   PC_W  sign-extended displacement
// res_rs       in   PC_W  Rs value (JR/JALR base)
// halt_req     in   1     HALT retiring in WB (older than anything in EX)
// pc           out  PC_W  fetch address this cycle
// fetch_en     out  1     instruction memory read enable
// flush        out  1     squash IF/ID contents (insert NOP)
// redirect     out  1     one-cycle pulse: PC redirected this cycle
// halted       out  1     core halted; sticky until reset
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): pc=RESET_PC, state=RUN, flush=0, redirect=0, halted=0, cnt=0.
//   fetch_en=0 while rst_n=0; 1 from the first cycle out of reset.
// - take = res_valid & (res_jump | (res_branch & res_taken)).
// - target = res_jmp_r ? res_rs + res_imm : res_pc_plus2 + res_imm; add mod 2^PC_W, wrap silently.
// - res_jmp_r without res_jump: treated as jump (decode guarantees this never occurs; assertion flags it).
// - Next-PC priority per cycle: rst_n=0 > halt_req > take > stall > pc+INSTR_BYTES (mod 2^PC_W).
//   - take overrides stall: the redirect is never lost.
// - redirect: combinational, = take & ~halt_req & state!=HALT; pc=target on the next edge (1-cycle latency).
// - States:
//   - RUN:
//     - take -> FLUSH, cnt=FLUSH_CYCLES-1.
//     - halt_req -> HALT.
//   - FLUSH:
//     - flush=1; pc advances normally unless stall.
//     - cnt==0 -> RUN; else cnt--.
//     - take -> reload pc, restart cnt=FLUSH_CYCLES-1 (stay FLUSH).
//     - halt_req -> HALT.
//   - HALT:
//     - pc frozen; fetch_en=0; flush=1; halted=1.
//     - res_valid, stall and halt_req ignored; exit only via reset.
// - flush: registered, asserted the cycle after redirect for exactly FLUSH_CYCLES cycles.
//   - stall does not extend flush.
// - Reset mid-FLUSH/HALT: returns to RUN at RESET_PC next cycle; pending redirect discarded.
// - pc is odd only if target is odd; no alignment check (exception support is future work).
// STRUCTURE
// - Shared include if_defs.vh:
//   - state encodings IF_RUN=2'b00, IF_FLUSH=2'b01, IF_HALT=2'b10.
//   - opcode constants J/JR/JAL/JALR/B* shared with the decode controls.
// - Sub-module pc_target_gen: combinational target mux + adder (PC_W); instanced once.
// - Top: state register, flush counter ($clog2(FLUSH_CYCLES+1) bits), PC register, next-PC mux.
// TESTING
// 1 Reset: rst_n=0 two cycles -> pc=0, flush=0, halted=0, fetch_en=0; release -> pc 0,2,4,6 on successive cycles.
// 2 Taken BEQZ: res_branch=1, res_taken=1, res_pc_plus2=16'h0010, res_imm=16'hFFF8
//   -> redirect=1 that cycle; pc=16'h0008 next; flush=1 exactly 2 cycles.
// 3 Not-taken branch + JR: res_taken=0 -> no redirect, pc+2.
//   Then res_jump=1, res_jmp_r=1, res_rs=16'h1234, res_imm=16'h0002 -> pc=16'h1236.
// 4 Redirect under stall: stall=1 with J to 16'h0100 (pc_plus2=16'h0040, imm=16'h00C0)
//   -> pc=16'h0100 next; second J in FLUSH cycle 1 -> new target, flush extended to 2 more cycles.
// 5 Halt/wrap: halt_req=1 same cycle as take -> no redirect, halted=1, pc frozen, fetch_en=0.
//   Reset -> RUN. pc=16'hFFFE, no stall -> pc=16'h0000.

Source files
------------

// File: rtl/if_pc_redirect_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM state encoding,
// control-flow opcodes shared with the decode controls, and the
// redirect-resolution helper used by the sequencer.
package if_pc_redirect_pkg;

   // Fetch sequencer states; encodings match the decode-side definitions.
   typedef enum logic [1:0] {
      IF_RUN   = 2'b00,
      IF_FLUSH = 2'b01,
      IF_HALT  = 2'b10
   } if_state_e;

   // Control-flow opcodes shared with the decode controls.
   localparam logic [5:0] OP_J    = 6'h02;
   localparam logic [5:0] OP_JAL  = 6'h03;
   localparam logic [5:0] OP_BEQZ = 6'h04;
   localparam logic [5:0] OP_BNEZ = 6'h05;
   localparam logic [5:0] OP_BLTZ = 6'h06;
   localparam logic [5:0] OP_BGEZ = 6'h07;
   localparam logic [5:0] OP_JR   = 6'h12;
   localparam logic [5:0] OP_JALR = 6'h13;

   // True for any opcode that can redirect fetch once resolved in EX.
   function automatic logic is_cf_opcode(input logic [5:0] op);
      logic hit;
      case (op)
         OP_J, OP_JAL, OP_JR, OP_JALR,
         OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: hit = 1'b1;
         default:                            hit = 1'b0;
      endcase
      return hit;
   endfunction

   // A resolved instruction redirects fetch when it is a jump of either
   // flavour or a branch whose condition evaluated true. A stray jmp_r bit
   // is treated as a jump so a decode bug never silently falls through.
   function automatic logic resolve_take(input logic valid,
                                         input logic jump,
                                         input logic jmp_r,
                                         input logic branch,
                                         input logic taken);
      return valid & (jump | jmp_r | (branch & taken));
   endfunction

endpackage

// File: rtl/if_pc_redirect_pc_target_gen.sv
// Redirect target generator: selects the base (Rs for register-relative
// jumps, otherwise PC+2 of the resolving instruction) and adds the
// sign-extended displacement modulo 2^PC_W.
module pc_target_gen #(
   parameter int PC_W = 16
) (
   input  logic            jmp_r,
   input  logic [PC_W-1:0] pc_plus2,
   input  logic [PC_W-1:0] imm,
   input  logic [PC_W-1:0] rs,
   output logic [PC_W-1:0] target
);

   logic [PC_W-1:0] base;

   // Base select and displacement add; carry out of the MSB is dropped so
   // targets wrap around the address space.
   always_comb begin
      base   = jmp_r ? rs : pc_plus2;
      target = base + imm;
   end

endmodule

// File: rtl/if_pc_redirect.sv
// Fetch-stage PC sequencer. Predicts not-taken (sequential fetch), redirects
// on a jump or taken branch resolved in EX, squashes the wrong-path IF/ID
// slots for FLUSH_CYCLES cycles after each redirect, and freezes fetch when
// a HALT retires. FLUSH_CYCLES is legal from 1 to 7.
module if_pc_redirect #(
   parameter int              PC_W         = 16,
   parameter logic [PC_W-1:0] RESET_PC     = '0,
   parameter int              INSTR_BYTES  = 2,
   parameter int              FLUSH_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            res_valid,
   input  logic            res_jump,
   input  logic            res_jmp_r,
   input  logic            res_branch,
   input  logic            res_taken,
   input  logic [PC_W-1:0] res_pc_plus2,
   input  logic [PC_W-1:0] res_imm,
   input  logic [PC_W-1:0] res_rs,
   input  logic            halt_req,
   output logic [PC_W-1:0] pc,
   output logic            fetch_en,
   output logic            flush,
   output logic            redirect,
   output logic            halted
);

   import if_pc_redirect_pkg::*;

   localparam int              CNT_W      = $clog2(FLUSH_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [PC_W-1:0]  PC_STEP    = PC_W'(INSTR_BYTES);

   if_state_e        state;
   if_state_e        state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic [PC_W-1:0]  pc_q;
   logic [PC_W-1:0]  pc_next;
   logic [PC_W-1:0]  target;
   logic             take;

   pc_target_gen #(
      .PC_W (PC_W)
   ) u_target (
      .jmp_r    (res_jmp_r),
      .pc_plus2 (res_pc_plus2),
      .imm      (res_imm),
      .rs       (res_rs),
      .target   (target)
   );

   assign take = resolve_take(res_valid, res_jump, res_jmp_r, res_branch, res_taken);

   // Next-state, flush counter and next-PC selection. Priority within a
   // cycle: halt_req > take > stall > sequential; a redirect wins over a
   // stall so it is never lost, and HALT ignores everything but reset.
   always_comb begin
      // NOTE: every variable gets a default before any branch, otherwise a
      // path that skips an assignment infers a latch.
      state_next = state;
      cnt_next   = cnt;
      pc_next    = pc_q;
      if (state == IF_HALT) begin
         state_next = IF_HALT;
      end else if (halt_req) begin
         state_next = IF_HALT;
      end else if (take) begin
         state_next = IF_FLUSH;
         cnt_next   = CNT_RELOAD;
         pc_next    = target;
      end else begin
         // The flush window counts down regardless of stall.
         if (state == IF_FLUSH) begin
            if (cnt == '0) begin
               state_next = IF_RUN;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end
         if (!stall) begin
            pc_next = pc_q + PC_STEP;
         end
      end
   end

   // State, flush counter and PC registers with synchronous reset; a reset
   // discards any redirect presented in the same cycle.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      if (!rst_n) begin
         state <= IF_RUN;
         cnt   <= '0;
         pc_q  <= RESET_PC;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         pc_q  <= pc_next;
      end
   end

   // Output decode: flush and halted come straight from the state register;
   // fetch is held off during reset and once halted.
   always_comb begin
      pc       = pc_q;
      fetch_en = rst_n & (state != IF_HALT);
      flush    = (state != IF_RUN);
      halted   = (state == IF_HALT);
      redirect = rst_n & take & ~halt_req & (state != IF_HALT);
   end

   // Decode only raises jmp_r together with jump.
   a_jmp_r_has_jump: assert property (@(posedge clk) disable iff (!rst_n)
      res_valid |-> (res_jump || !res_jmp_r));

   // The flush counter never exceeds its reload value.
   a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
      cnt <= CNT_RELOAD);

   // The state register only ever holds one of the three defined states.
   a_state_legal: assert property (@(posedge clk) disable iff (!rst_n)
      state inside {IF_RUN, IF_FLUSH, IF_HALT});

endmodule

// File: tb/tb_if_pc_redirect.sv
// Self-checking bench for the fetch-stage PC sequencer: a directed vector
// table, hand-written multi-cycle sequences, then random stimulus against a
// cycle-level reference model.
module tb_if_pc_redirect;

   localparam int PC_W = 16;
   localparam int FC   = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            stall = 1'b0;
   logic            res_valid = 1'b0;
   logic            res_jump = 1'b0;
   logic            res_jmp_r = 1'b0;
   logic            res_branch = 1'b0;
   logic            res_taken = 1'b0;
   logic [PC_W-1:0] res_pc_plus2 = '0;
   logic [PC_W-1:0] res_imm = '0;
   logic [PC_W-1:0] res_rs = '0;
   logic            halt_req = 1'b0;
   logic [PC_W-1:0] pc;
   logic            fetch_en;
   logic            flush;
   logic            redirect;
   logic            halted;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   if_pc_redirect #(
      .PC_W         (PC_W),
      .RESET_PC     (16'h0000),
      .INSTR_BYTES  (2),
      .FLUSH_CYCLES (FC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .stall        (stall),
      .res_valid    (res_valid),
      .res_jump     (res_jump),
      .res_jmp_r    (res_jmp_r),
      .res_branch   (res_branch),
      .res_taken    (res_taken),
      .res_pc_plus2 (res_pc_plus2),
      .res_imm      (res_imm),
      .res_rs       (res_rs),
      .halt_req     (halt_req),
      .pc           (pc),
      .fetch_en     (fetch_en),
      .flush        (flush),
      .redirect     (redirect),
      .halted       (halted)
   );

   typedef struct {
      logic            r, st, v, j, jr, b, t, h;
      logic [PC_W-1:0] p2, im, rs;
      logic [PC_W-1:0] e_pc;
      logic            e_fetch, e_flush, e_redir, e_halted;
   } vec_t;

   vec_t tbl[18];

   function automatic vec_t mk(input logic r, st, v, j, jr, b, t, h,
                               input logic [PC_W-1:0] p2, im, rsv, e_pc,
                               input logic ef, efl, er, eh);
      vec_t x;
      x.r = r; x.st = st; x.v = v; x.j = j; x.jr = jr; x.b = b; x.t = t; x.h = h;
      x.p2 = p2; x.im = im; x.rs = rsv; x.e_pc = e_pc;
      x.e_fetch = ef; x.e_flush = efl; x.e_redir = er; x.e_halted = eh;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic [PC_W-1:0] e_pc,
                             input logic e_fetch, e_flush, e_redir, e_halted);
      check({tag, ".pc"},       32'(pc),       32'(e_pc));
      check({tag, ".fetch_en"}, 32'(fetch_en), 32'(e_fetch));
      check({tag, ".flush"},    32'(flush),    32'(e_flush));
      check({tag, ".redirect"}, 32'(redirect), 32'(e_redir));
      check({tag, ".halted"},   32'(halted),   32'(e_halted));
   endtask

   // One cycle: drive inputs after the falling edge, settle, return before
   // the next rising edge so the caller can sample outputs.
   task automatic go(input logic r, st, v, j, jr, b, t, h,
                     input logic [PC_W-1:0] p2, im, rsv);
      @(negedge clk);
      rst_n = r; stall = st; res_valid = v; res_jump = j; res_jmp_r = jr;
      res_branch = b; res_taken = t; halt_req = h;
      res_pc_plus2 = p2; res_imm = im; res_rs = rsv;
      #1;
   endtask

   task automatic idle();
      go(1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
   endtask

   // Jump with target p2+im, optional stall.
   task automatic jump(input logic st, input logic [PC_W-1:0] p2, im);
      go(1, st, 1, 1, 0, 0, 0, 0, p2, im, 16'h0);
   endtask

   // Reference model state: fetch address, remaining flush cycles, halt flag.
   int m_pc;
   int m_left;
   bit m_halted;

   initial begin
      // Reset, sequential fetch, taken/not-taken branch, JR, stall in RUN.
      tbl[0]  = mk(0,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0000, 0,0,0,0);
      tbl[1]  = mk(0,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0000, 0,0,0,0);
      tbl[2]  = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0000, 1,0,0,0);
      tbl[3]  = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0002, 1,0,0,0);
      tbl[4]  = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0004, 1,0,0,0);
      tbl[5]  = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0006, 1,0,0,0);
      tbl[6]  = mk(1,0,1,0,0,1,1,0, 16'h0010, 16'hFFF8, 16'h0,    16'h0008, 1,0,1,0);
      tbl[7]  = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h0008, 1,1,0,0);
      tbl[8]  = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h000A, 1,1,0,0);
      tbl[9]  = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h000C, 1,0,0,0);
      tbl[10] = mk(1,0,1,0,0,1,0,0, 16'h0010, 16'hFFF8, 16'h0,    16'h000E, 1,0,0,0);
      tbl[11] = mk(1,0,1,1,1,0,0,0, 16'h0050, 16'h0002, 16'h1234, 16'h0010, 1,0,1,0);
      tbl[12] = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h1236, 1,1,0,0);
      tbl[13] = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h1238, 1,1,0,0);
      tbl[14] = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h123A, 1,0,0,0);
      tbl[15] = mk(1,1,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h123C, 1,0,0,0);
      tbl[16] = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h123C, 1,0,0,0);
      tbl[17] = mk(1,0,0,0,0,0,0,0, 16'h0,    16'h0,    16'h0,    16'h123E, 1,0,0,0);

      @(posedge clk);
      for (int i = 0; i < 18; i++) begin
         go(tbl[i].r, tbl[i].st, tbl[i].v, tbl[i].j, tbl[i].jr, tbl[i].b, tbl[i].t,
            tbl[i].h, tbl[i].p2, tbl[i].im, tbl[i].rs);
         check_outs($sformatf("row%0d", i), tbl[i].e_pc, tbl[i].e_fetch,
                    tbl[i].e_flush, tbl[i].e_redir, tbl[i].e_halted);
      end

      // Redirect under stall, then a second jump in the first flush cycle.
      jump(1, 16'h0040, 16'h00C0); check_outs("stall_j",  16'h1240, 1, 0, 1, 0);
      jump(0, 16'h0200, 16'h0010); check_outs("flush_j",  16'h0100, 1, 1, 1, 0);
      idle();                      check_outs("reflush1", 16'h0210, 1, 1, 0, 0);
      idle();                      check_outs("reflush2", 16'h0212, 1, 1, 0, 0);
      idle();                      check_outs("reflush3", 16'h0214, 1, 0, 0, 0);

      // Stall during flush does not stretch the flush window.
      jump(0, 16'h0300, 16'h0000); check_outs("j300",     16'h0216, 1, 0, 1, 0);
      go(1, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      check_outs("fl_stall1", 16'h0300, 1, 1, 0, 0);
      go(1, 1, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      check_outs("fl_stall2", 16'h0300, 1, 1, 0, 0);
      idle();                      check_outs("fl_done",  16'h0300, 1, 0, 0, 0);

      // Halt in the same cycle as a take: no redirect, then frozen.
      go(1, 0, 1, 1, 0, 0, 0, 1, 16'h0500, 16'h0, 16'h0);
      check_outs("halt_take", 16'h0302, 1, 0, 0, 0);
      go(1, 1, 1, 1, 0, 0, 0, 0, 16'h0600, 16'h0, 16'h0);
      check_outs("halted1",   16'h0302, 0, 1, 0, 1);
      go(1, 0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0);
      check_outs("halted2",   16'h0302, 0, 1, 0, 1);
      go(0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0);
      check_outs("halt_rst",  16'h0302, 0, 1, 0, 1);
      idle();                      check_outs("post_rst", 16'h0000, 1, 0, 0, 0);

      // Wrap: redirect to 0xFFFE, then sequential fetch wraps to 0.
      jump(0, 16'h0000, 16'hFFFE); check_outs("j_fffe",   16'h0002, 1, 0, 1, 0);
      idle();                      check_outs("at_fffe",  16'hFFFE, 1, 1, 0, 0);
      idle();                      check_outs("wrap0",    16'h0000, 1, 1, 0, 0);
      idle();                      check_outs("wrap2",    16'h0002, 1, 0, 0, 0);

      // Reset mid-flush with a take pending: redirect discarded.
      jump(0, 16'h0700, 16'h0000); check_outs("j700",     16'h0004, 1, 0, 1, 0);
      go(0, 0, 1, 1, 0, 0, 0, 0, 16'h0800, 16'h0, 16'h0);
      check_outs("rst_flush", 16'h0700, 0, 1, 0, 0);
      idle();                      check_outs("rst_done", 16'h0000, 1, 0, 0, 0);

      // Random stimulus against the reference model.
      m_pc = 2; m_left = 0; m_halted = 0;
      for (int n = 0; n < 3000; n++) begin
         logic r, st, v, j, jr, b, t, h, tk;
         logic [PC_W-1:0] p2, im, rsv;
         int tgt;
         r   = ($urandom_range(0, 39) != 0);
         st  = ($urandom_range(0, 3) == 0);
         v   = 1'($urandom);
         j   = ($urandom_range(0, 2) == 0);
         jr  = j & 1'($urandom);
         b   = 1'($urandom);
         t   = 1'($urandom);
         h   = ($urandom_range(0, 59) == 0);
         p2  = 16'($urandom);
         im  = 16'($urandom);
         rsv = 16'($urandom);
         tk  = v & (j | (b & t));
         tgt = ((jr ? int'(rsv) : int'(p2)) + int'(im)) % 65536;
         go(r, st, v, j, jr, b, t, h, p2, im, rsv);
         check_outs($sformatf("rand%0d", n), 16'(m_pc), r && !m_halted,
                    m_halted || (m_left > 0), r && !m_halted && !h && tk, m_halted);
         if (!r) begin
            m_pc = 0; m_left = 0; m_halted = 0;
         end else if (m_halted) begin
            m_halted = 1;
         end else if (h) begin
            m_halted = 1;
         end else if (tk) begin
            m_pc = tgt; m_left = FC;
         end else begin
            if (m_left > 0) m_left--;
            if (!st) m_pc = (m_pc + 2) % 65536;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
